// File: rtl/ram_16x8_sync.sv
// ram_16x8_sync: 16 x 8 simple dual-port RAM, one write port and one read port,
// single clock, registered read data (1-cycle latency).
// Synchronous active-high reset clears every word and the read register.
// Optional macro RAM_WR_BYPASS_EN: write-first forwarding on a same-address
// read/write collision. When it is undefined, a collision reads first and returns
// the old contents.

module ram_16x8_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enable,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_next_c;

  // Read-port source: stored word, or the incoming write data when forwarding is built in
  always_comb begin
    rd_next_c = mem[rd_addr];
`ifdef RAM_WR_BYPASS_EN
    if (wr_enable && (wr_addr == rd_addr)) begin
      rd_next_c = wr_data;
    end
`endif
  end

  // Storage array: reset clears every word, and reset takes priority over writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_enable) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read data: holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_enable) begin
      rd_data <= rd_next_c;
    end
  end

endmodule

// File: tb/tb_ram_16x8_sync.sv
// tb_ram_16x8_sync: scoreboard bench for ram_16x8_sync.
// Stimulus pushes the expected rd_data for every checked cycle. A monitor pops
// that value and compares it on the falling edge after the active edge.

module tb_ram_16x8_sync;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_enable = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_enable = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  logic          chk_en = 1'b0;
  logic          chk_q  = 1'b0;

  logic [DW-1:0] exp_q [$];
  string         tag_q [$];
  logic [DW-1:0] shadow [DEPTH];

  int n_vec  = 0;
  int n_miss = 0;

  ram_16x8_sync dut (
    .clk       (clk),
    .rst       (rst),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_enable (rd_enable),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Remember which active edges produced a result that must be checked
  always @(posedge clk) chk_q <= chk_en;

  // Monitor: pop one expectation per checked edge and compare
  always @(negedge clk) begin
    if (chk_q) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL underflow: got rd_data=%h, required an expectation in the queue", rd_data);
      end else begin
        logic [DW-1:0] e;
        string         t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        if (rd_data !== e) begin
          n_miss++;
          $display("FAIL %s: got rd_data=%h, required %h", t, rd_data, e);
        end
      end
    end
  end

  // Apply one cycle of stimulus; optionally queue the rd_data expected after the edge
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic chk, input logic [DW-1:0] exp_v, input string tag);
    @(negedge clk);
    rst       = r;
    wr_enable = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_enable = re;
    rd_addr   = ra;
    chk_en    = chk;
    if (chk) begin
      exp_q.push_back(exp_v);
      tag_q.push_back(tag);
    end
    if (r) begin
      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
    end else if (we) begin
      shadow[wa] = wd;
    end
  endtask

  logic [DW-1:0] coll_exp;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;

    // Reset dominance: the write and read issued during reset are discarded
    step(1'b1, 1'b1, 4'd10, 8'd23, 1'b0, 4'd0,  1'b1, 8'h00, "rst_wr");
    step(1'b1, 1'b0, 4'd0,  8'd0,  1'b1, 4'd10, 1'b1, 8'h00, "rst_rd");
    step(1'b0, 1'b0, 4'd0,  8'd0,  1'b1, 4'd10, 1'b1, 8'h00, "post_rst_rd10");

    // Write then read
    step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b1, 8'h00, "wr3_hold");
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'hA5, "rd3");

    // Same-address collision
`ifdef RAM_WR_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    step(1'b0, 1'b1, 4'd5, 8'h11, 1'b0, 4'd0, 1'b0, 8'h00, "");
    step(1'b0, 1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 1'b1, coll_exp, "collide5");
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 8'h22, "rd5_after");

    // Different addresses in the same cycle both complete
    step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd3, 1'b1, 8'hA5, "rw_diff");
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 1'b1, 8'h3C, "rd7");

    // Hold: rd_data keeps its value while reads are off, even as addr 3 is rewritten
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'hA5, "rd3_again");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 4'd3, 1'b1, 8'hA5, "hold");
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b1, 8'h00, "rd3_new");

    // Streaming: 20 back-to-back writes, then 20 back-to-back reads
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, AW'($urandom_range(DEPTH-1)), DW'($urandom), 1'b0, 4'd0,
           1'b0, 8'h00, "");
    for (int i = 0; i < 20; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(DEPTH-1));
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, a, 1'b1, shadow[a], "stream_rd");
    end

    // Reset mid-operation: fill all words, reset during an active write and read
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b0, 1'b1, AW'(i), DW'(i * 17 + 1), 1'b0, 4'd0, 1'b0, 8'h00, "");
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15, 1'b1, 8'h00 + DW'(15 * 17 + 1), "fill_rd15");
    step(1'b1, 1'b1, 4'd2, 8'hEE, 1'b1, 4'd2, 1'b1, 8'h00, "mid_rst");
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, AW'(i), 1'b1, 8'h00, "cleared_rd");

    // Drain: idle until every queued expectation is checked, with a bound
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, "");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
